car_motion_update: RTL and testbench

//  Per-frame kinematics stage for one car. Runs on each frame tick:
//   - integrates acceleration into velocity, then velocity into position;
//   - presents the candidate position/velocity to the track collision checker;
//   - commits the move, or rejects it and bounces the car.

---
 rtl/game_pkg.sv | 17 +
 rtl/sat_add.sv | 16 +
 rtl/car_motion_update.sv | 129 ++++++++++++
 tb/tb_car_motion_update.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared widths, motion FSM states, kinematics record and limits for the car motion stage.
package game_pkg;
  localparam int MAP_H_WIDTH = 11;
  localparam int MAP_V_WIDTH = 10;
  localparam int VELOCITY_INTEGER_WIDTH = 6;
  localparam int VELOCITY_FRACTION_WIDTH = 6;
  localparam int VELOCITY_WIDTH = VELOCITY_INTEGER_WIDTH + VELOCITY_FRACTION_WIDTH;
  localparam int V_MAX = 12;
  localparam int FRICTION_SHIFT = 4;
  typedef enum logic [2:0] {IDLE, ACCEL, PROPOSE, CHECK, COMMIT, BOUNCE} motion_state_e;
  typedef struct packed {
    logic [MAP_H_WIDTH-1:0] x;
    logic [MAP_V_WIDTH-1:0] y;
    logic [VELOCITY_WIDTH-1:0] v_x;
    logic [VELOCITY_WIDTH-1:0] v_y;
  } car_kin_t;
endpackage

// File: rtl/sat_add.sv
// sat_add: signed W-bit add computed in W+1 bits, clamped to [MIN, MAX].
module sat_add #(
  parameter int W = 12,
  parameter logic signed [W-1:0] MAX = {1'b0, {(W-1){1'b1}}},
  parameter logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}}
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);
  logic signed [W:0] s;
  always_comb begin
    s = {a[W-1], a} + {b[W-1], b};
    sum = s > MAX ? MAX : s < MIN ? MIN : s[W-1:0];
  end
endmodule

// File: rtl/car_motion_update.sv
// car_motion_update: per-frame accel/propose/check/commit-or-bounce kinematics for one car.
// CAR_FRICTION_EN: decay velocity by v>>>FRICTION_SHIFT before acceleration is applied.
module car_motion_update
  import game_pkg::*;
#(
  parameter int MAP_H_W = game_pkg::MAP_H_WIDTH,
  parameter int MAP_V_W = game_pkg::MAP_V_WIDTH,
  parameter int VEL_INT_W = game_pkg::VELOCITY_INTEGER_WIDTH,
  parameter int VEL_FRAC_W = game_pkg::VELOCITY_FRACTION_WIDTH,
  parameter int V_MAX = game_pkg::V_MAX,
  parameter int CHECK_WAIT = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_init_load,
  input  logic [MAP_H_W-1:0]                i_init_x,
  input  logic [MAP_V_W-1:0]                i_init_y,
  input  logic                              i_frame_tick,
  input  logic [VEL_INT_W+VEL_FRAC_W-1:0]   i_acc_x,
  input  logic [VEL_INT_W+VEL_FRAC_W-1:0]   i_acc_y,
  output logic [MAP_H_W-1:0]                o_cand_x,
  output logic [MAP_V_W-1:0]                o_cand_y,
  output logic [VEL_INT_W+VEL_FRAC_W-1:0]   o_cand_v_x,
  output logic [VEL_INT_W+VEL_FRAC_W-1:0]   o_cand_v_y,
  input  logic                              i_collision,
  output logic [MAP_H_W-1:0]                o_x,
  output logic [MAP_V_W-1:0]                o_y,
  output logic [VEL_INT_W+VEL_FRAC_W-1:0]   o_v_x,
  output logic [VEL_INT_W+VEL_FRAC_W-1:0]   o_v_y,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_bumped
);
  localparam int VW = VEL_INT_W + VEL_FRAC_W;
  localparam int PXW = MAP_H_W + VEL_FRAC_W;
  localparam int PYW = MAP_V_W + VEL_FRAC_W;
  localparam int CW = $clog2(CHECK_WAIT + 1);
  localparam logic signed [VW-1:0] V_LIM = VW'(V_MAX << VEL_FRAC_W);
  localparam logic signed [VW-1:0] V_NEG = {1'b1, {(VW-1){1'b0}}};
  motion_state_e state, state_nx;
  logic signed [VW-1:0] v_x, v_y, cv_x, cv_y, fv_x, fv_y, av_x, av_y;
  logic signed [PXW-1:0] px, cpx, spx;
  logic signed [PYW-1:0] py, cpy, spy;
  logic [CW-1:0] cnt;
  logic last;
  function automatic logic signed [VW-1:0] bounce(input logic signed [VW-1:0] v);
    logic signed [VW-1:0] m;
    m = v == V_NEG ? v + 1'b1 : v;
    return -(m >>> 1);
  endfunction
`ifdef CAR_FRICTION_EN
  assign fv_x = v_x - (v_x >>> FRICTION_SHIFT);
  assign fv_y = v_y - (v_y >>> FRICTION_SHIFT);
`else
  assign fv_x = v_x;
  assign fv_y = v_y;
`endif
  sat_add #(.W(VW), .MAX(V_LIM), .MIN(-V_LIM)) u_vx (.a(fv_x), .b(i_acc_x), .sum(av_x));
  sat_add #(.W(VW), .MAX(V_LIM), .MIN(-V_LIM)) u_vy (.a(fv_y), .b(i_acc_y), .sum(av_y));
  sat_add #(.W(PXW)) u_px (.a(px), .b(PXW'(cv_x)), .sum(spx));
  sat_add #(.W(PYW)) u_py (.a(py), .b(PYW'(cv_y)), .sum(spy));
  assign last = cnt == CW'(CHECK_WAIT - 1);
  always_ff @(posedge i_clk)
    state <= (!i_rst_n || i_init_load) ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_frame_tick ? ACCEL : IDLE;
      ACCEL:   state_nx = PROPOSE;
      PROPOSE: state_nx = CHECK;
      CHECK:   state_nx = !last ? CHECK : i_collision ? BOUNCE : COMMIT;
      default: state_nx = IDLE;
    endcase
  end
  // Candidate velocity lives in cv_* from ACCEL on; committed v_* only moves on COMMIT/BOUNCE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      px <= '0;
      py <= '0;
      v_x <= '0;
      v_y <= '0;
      cv_x <= '0;
      cv_y <= '0;
      cpx <= '0;
      cpy <= '0;
      cnt <= '0;
      o_done <= 1'b0;
      o_bumped <= 1'b0;
    end else if (i_init_load) begin
      px <= {i_init_x, {VEL_FRAC_W{1'b0}}};
      py <= {i_init_y, {VEL_FRAC_W{1'b0}}};
      v_x <= '0;
      v_y <= '0;
      cnt <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= state == COMMIT || state == BOUNCE;
      cnt <= state == CHECK ? cnt + 1'b1 : '0;
      if (state == ACCEL) begin
        cv_x <= av_x;
        cv_y <= av_y;
      end
      if (state == PROPOSE) begin
        cpx <= spx;
        cpy <= spy;
      end
      if (state == COMMIT) begin
        px <= cpx;
        py <= cpy;
        v_x <= cv_x;
        v_y <= cv_y;
      end
      if (state == BOUNCE) begin
        v_x <= bounce(cv_x);
        v_y <= bounce(cv_y);
      end
      if (state == COMMIT || state == BOUNCE) o_bumped <= state == BOUNCE;
    end
  end
  assign o_x = px[PXW-1 -: MAP_H_W];
  assign o_y = py[PYW-1 -: MAP_V_W];
  assign o_cand_x = cpx[PXW-1 -: MAP_H_W];
  assign o_cand_y = cpy[PYW-1 -: MAP_V_W];
  assign o_v_x = v_x;
  assign o_v_y = v_y;
  assign o_cand_v_x = cv_x;
  assign o_cand_v_y = cv_y;
  assign o_busy = state != IDLE;
endmodule

// File: tb/tb_car_motion_update.sv
// tb_car_motion_update: scoreboard bench for car_motion_update; honours CAR_FRICTION_EN in its model.
module tb_car_motion_update;
  import game_pkg::*;
  typedef struct packed {car_kin_t k; logic bumped;} exp_t;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_init_load = 1'b0, i_frame_tick = 1'b0, i_collision = 1'b0;
  logic [10:0] i_init_x = '0;
  logic [9:0] i_init_y = '0;
  logic [11:0] i_acc_x = '0, i_acc_y = '0;
  logic [10:0] o_cand_x, o_x;
  logic [9:0] o_cand_y, o_y;
  logic [11:0] o_cand_v_x, o_cand_v_y, o_v_x, o_v_y;
  logic o_busy, o_done, o_bumped;
  exp_t obs;
  exp_t q[$];
  int checks = 0, errors = 0;
  int mpx, mpy, mvx, mvy, mcx, mcvx;
  car_motion_update dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_init_load(i_init_load), .i_init_x(i_init_x),
    .i_init_y(i_init_y), .i_frame_tick(i_frame_tick), .i_acc_x(i_acc_x), .i_acc_y(i_acc_y),
    .o_cand_x(o_cand_x), .o_cand_y(o_cand_y), .o_cand_v_x(o_cand_v_x), .o_cand_v_y(o_cand_v_y),
    .i_collision(i_collision), .o_x(o_x), .o_y(o_y), .o_v_x(o_v_x), .o_v_y(o_v_y),
    .o_busy(o_busy), .o_done(o_done), .o_bumped(o_bumped)
  );
  always #5 i_clk = ~i_clk;
  assign obs = {o_x, o_y, o_v_x, o_v_y, o_bumped};

  function automatic int clampi(int v, int lo, int hi);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction

  function automatic int fric(int v);
`ifdef CAR_FRICTION_EN
    return v - (v >>> FRICTION_SHIFT);
`else
    return v;
`endif
  endfunction

  task automatic model_step(input int ax, input int ay, input bit coll, output exp_t e);
    int nvx, nvy, cy;
    nvx = clampi(fric(mvx) + ax, -V_MAX * 64, V_MAX * 64);
    nvy = clampi(fric(mvy) + ay, -V_MAX * 64, V_MAX * 64);
    mcx = clampi(mpx + nvx, -65536, 65535);
    mcvx = nvx;
    cy = clampi(mpy + nvy, -32768, 32767);
    if (coll) begin
      mvx = -(nvx >>> 1);
      mvy = -(nvy >>> 1);
    end else begin
      mpx = mcx;
      mpy = cy;
      mvx = nvx;
      mvy = nvy;
    end
    e.k.x = 11'(mpx >>> 6);
    e.k.y = 10'(mpy >>> 6);
    e.k.v_x = 12'(mvx);
    e.k.v_y = 12'(mvy);
    e.bumped = coll;
  endtask

  task automatic pulse_tick(input int ax, input int ay, input bit coll);
    @(negedge i_clk);
    i_acc_x = 12'(ax);
    i_acc_y = 12'(ay);
    i_collision = coll;
    i_frame_tick = 1'b1;
    @(negedge i_clk);
    i_frame_tick = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!o_done && n < 20) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  task automatic do_update(input int ax, input int ay, input bit coll, output int lat);
    exp_t e;
    model_step(ax, ay, coll, e);
    q.push_back(e);
    pulse_tick(ax, ay, coll);
    wait_done(lat);
  endtask

  task automatic do_init(input int x, input int y);
    @(negedge i_clk);
    i_init_x = 11'(x);
    i_init_y = 10'(y);
    i_init_load = 1'b1;
    @(negedge i_clk);
    i_init_load = 1'b0;
    mpx = x * 64;
    mpy = y * 64;
    mvx = 0;
    mvy = 0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_x, o_y, o_v_x, o_v_y, o_cand_x, o_cand_y, o_cand_v_x, o_cand_v_y, o_busy, o_done, o_bumped} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got x=%h y=%h vx=%h busy=%b done=%b want all 0", o_x, o_y, o_v_x, o_busy, o_done);
    end
    i_rst_n = 1'b1;
    mpx = 0; mpy = 0; mvx = 0; mvy = 0;
  endtask

  task automatic test_basic;
    exp_t e;
    int lat;
    do_init(100, -300);
    do_update(64, 0, 0, lat);
    e = q.pop_front();
    checks++;
    if (!o_done || lat != 5) begin errors++; $display("FAIL latency got %0d want 5", lat); end
    checks++;
    if (obs !== e) begin errors++; $display("FAIL first_commit got %h want %h", obs, e); end
    checks++;
    if (o_x !== 11'd101 || o_v_x !== 12'd64 || o_bumped !== 1'b0) begin
      errors++; $display("FAIL first_move got x=%0d vx=%h want x=101 vx=040", o_x, o_v_x);
    end
    do_update(192, 0, 0, lat);
    e = q.pop_front();
    checks++;
    if (!o_done || obs !== e) begin errors++; $display("FAIL reach_4 got %h want %h", obs, e); end
    do_update(0, 0, 1, lat);
    e = q.pop_front();
    checks++;
    if (!o_done || obs !== e) begin errors++; $display("FAIL bounce got %h want %h", obs, e); end
    checks++;
    if (o_v_x !== 12'hF80 || o_x !== 11'd105 || o_bumped !== 1'b1) begin
      errors++; $display("FAIL bounce_value got x=%0d vx=%h bumped=%b want x=105 vx=f80 bumped=1", o_x, o_v_x, o_bumped);
    end
  endtask

  task automatic test_saturation;
    exp_t e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_update(i < 3 ? 768 : -768, 0, 0, lat);
      e = q.pop_front();
      checks++;
      if (!o_done || obs !== e) begin errors++; $display("FAIL vsat_%0d got %h want %h", i, obs, e); end
    end
    checks++;
    if (o_v_x !== 12'hD00) begin errors++; $display("FAIL vsat_neg got %h want d00", o_v_x); end
    do_init(1000, -500);
    for (int i = 0; i < 3; i++) begin
      do_update(i == 0 ? 768 : 0, i == 0 ? -768 : 0, 0, lat);
      e = q.pop_front();
      checks++;
      if (!o_done || obs !== e) begin errors++; $display("FAIL psat_%0d got %h want %h", i, obs, e); end
    end
    checks++;
    if (o_x !== 11'd1023 || o_y !== 10'h200) begin
      errors++; $display("FAIL pos_extreme got x=%h y=%h want x=3ff y=200", o_x, o_y);
    end
  endtask

  task automatic test_tick_in_check;
    exp_t e;
    int n;
    do_init(0, 0);
    model_step(320, 64, 0, e);
    q.push_back(e);
    pulse_tick(320, 64, 0);
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_cand_x !== 11'(mcx >>> 6) || o_cand_v_x !== 12'(mcvx)) begin
      errors++; $display("FAIL cand_in_check got x=%0d vx=%h want x=%0d vx=%h", o_cand_x, o_cand_v_x, mcx >>> 6, 12'(mcvx));
    end
    i_frame_tick = 1'b1;
    @(negedge i_clk);
    i_frame_tick = 1'b0;
    n = 0;
    repeat (15) begin
      if (o_done) begin
        n++;
        if (q.size() > 0) begin
          e = q.pop_front();
          checks++;
          if (obs !== e) begin errors++; $display("FAIL tick_check_commit got %h want %h", obs, e); end
        end
      end
      @(negedge i_clk);
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL tick_in_check dones got %0d want 1", n); end
    pulse_tick(0, 0, 0);
    repeat (2) @(negedge i_clk);
    i_init_x = 11'd50;
    i_init_y = 10'd60;
    i_init_load = 1'b1;
    @(negedge i_clk);
    i_init_load = 1'b0;
    mpx = 50 * 64; mpy = 60 * 64; mvx = 0; mvy = 0;
    n = 0;
    repeat (10) begin
      if (o_done) n++;
      @(negedge i_clk);
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL init_in_check dones got %0d want 0", n); end
    checks++;
    if ({o_x, o_y, o_v_x, o_v_y, o_busy} !== {11'd50, 10'd60, 24'd0, 1'b0}) begin
      errors++; $display("FAIL init_in_check state got x=%0d y=%0d vx=%h vy=%h busy=%b want 50 60 0 0 0", o_x, o_y, o_v_x, o_v_y, o_busy);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int lat, n;
    do_init(-20, 30);
    do_update(100, -100, 0, lat);
    e = q.pop_front();
    checks++;
    if (!o_done || obs !== e) begin errors++; $display("FAIL pre_reset got %h want %h", obs, e); end
    pulse_tick(0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_x, o_y, o_v_x, o_v_y, o_cand_x, o_cand_y, o_cand_v_x, o_cand_v_y, o_busy, o_done, o_bumped} !== '0) begin
      errors++; $display("FAIL reset_mid got x=%h y=%h vx=%h busy=%b done=%b want all 0", o_x, o_y, o_v_x, o_busy, o_done);
    end
    i_rst_n = 1'b1;
    mpx = 0; mpy = 0; mvx = 0; mvy = 0;
    n = 0;
    repeat (10) begin
      if (o_done) n++;
      @(negedge i_clk);
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL reset_mid dones got %0d want 0", n); end
  endtask

  task automatic test_friction;
    exp_t e;
    int lat;
    logic [11:0] want;
`ifdef CAR_FRICTION_EN
    want = 12'd480;
`else
    want = 12'd512;
`endif
    do_init(0, 0);
    for (int i = 0; i < 2; i++) begin
      do_update(i == 0 ? 512 : 0, 0, 0, lat);
      e = q.pop_front();
      checks++;
      if (!o_done || obs !== e) begin errors++; $display("FAIL friction_%0d got %h want %h", i, obs, e); end
    end
    checks++;
    if (o_v_x !== want) begin errors++; $display("FAIL friction_value got %h want %h", o_v_x, want); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat, ax, ay;
    bit coll;
    do_init(-400, 200);
    for (int i = 0; i < 10; i++) begin
      ax = int'($urandom_range(0, 400)) - 200;
      ay = int'($urandom_range(0, 400)) - 200;
      coll = $urandom_range(0, 3) == 0;
      do_update(ax, ay, coll, lat);
      e = q.pop_front();
      checks++;
      if (!o_done || obs !== e) begin errors++; $display("FAIL b2b_%0d got %h want %h", i, obs, e); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_tick_in_check;
    test_reset_mid;
    test_friction;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
